// File: rtl/pkg_common.sv
// Constants shared by the uCode sequencer subsystem packages.
package pkg_common;
    localparam int BYTE_W      = 8;
    // One bit wider than the largest address so start+count cannot wrap.
    localparam int ADDR_CALC_W = 9;
endpackage

// File: rtl/pkg_ucode_sequencer.sv
// Header layout, loader state encoding and uCode address type for the sequencer.
package pkg_ucode_sequencer;
    import pkg_common::*;

    localparam int HDR_FIELD_W         = BYTE_W;
    localparam int HDR_START_LSB       = 0;
    localparam int HDR_COUNT_LSB       = BYTE_W;
    localparam int UCODE_DEPTH_DEFAULT = 64;

    typedef logic [$clog2(UCODE_DEPTH_DEFAULT)-1:0] ucode_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } loader_state_e;
endpackage

// File: rtl/ucode_loader.sv
// Streams a header plus instruction words from the config port into uCode memory,
// rejecting out-of-range headers by draining their payload without writing.
module ucode_loader #(
    parameter int UCODE_DEPTH = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [INSTR_WIDTH-1:0]         cfg_data_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic                           seq_busy_i,
    output logic                           mem_we_o,
    output logic [$clog2(UCODE_DEPTH)-1:0] mem_addr_o,
    output logic [INSTR_WIDTH-1:0]         mem_wdata_o,
    output logic                           loader_busy_o,
    output logic                           done_o,
    output logic                           err_o
);
    import pkg_common::*;
    import pkg_ucode_sequencer::*;

    localparam int AW = $clog2(UCODE_DEPTH);
    localparam logic [ADDR_CALC_W-1:0] DEPTH_W   = ADDR_CALC_W'(UCODE_DEPTH);
    localparam logic [HDR_FIELD_W-1:0] CNT_ONE   = HDR_FIELD_W'(1);
    localparam logic [AW-1:0]          ADDR_ONE  = AW'(1);

    loader_state_e           state_reg;
    logic [AW-1:0]           addr_reg;
    logic [HDR_FIELD_W-1:0]  remaining_reg;
    logic                    mem_we_reg;
    logic [AW-1:0]           mem_addr_reg;
    logic [INSTR_WIDTH-1:0]  mem_wdata_reg;
    logic                    done_reg;
    logic                    err_reg;

    logic                    xfer;
    logic [HDR_FIELD_W-1:0]  hdr_start;
    logic [HDR_FIELD_W-1:0]  hdr_count;
    logic [ADDR_CALC_W-1:0]  hdr_end;
    logic                    hdr_bad;

    always_comb begin
        hdr_start = cfg_data_i[HDR_START_LSB +: HDR_FIELD_W];
        hdr_count = cfg_data_i[HDR_COUNT_LSB +: HDR_FIELD_W];
        hdr_end   = ADDR_CALC_W'(hdr_start) + ADDR_CALC_W'(hdr_count);
        hdr_bad   = (ADDR_CALC_W'(hdr_start) >= DEPTH_W) || (hdr_end > DEPTH_W);
    end

    // The done_o cycle still belongs to the completion handshake, so new
    // headers are held off and the loader still reports busy.
    assign cfg_ready_o   = !rst_i &&
                           (((state_reg == IDLE) && !seq_busy_i && !done_reg) ||
                            (state_reg == LOAD) || (state_reg == DRAIN));
    assign xfer          = cfg_valid_i && cfg_ready_o;
    assign loader_busy_o = (state_reg != IDLE) || done_reg;

    assign mem_we_o    = mem_we_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        if (hdr_bad) begin
                            err_reg       <= 1'b1;
                            remaining_reg <= hdr_count;
                            state_reg     <= (hdr_count == '0) ? IDLE : DRAIN;
                        end else if (hdr_count == '0) begin
                            state_reg <= DONE;
                        end else begin
                            addr_reg      <= hdr_start[AW-1:0];
                            remaining_reg <= hdr_count;
                            state_reg     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= addr_reg;
                        mem_wdata_reg <= cfg_data_i;
                        remaining_reg <= remaining_reg - CNT_ONE;
                        // Holding the address on the last word keeps a load
                        // ending at the top of memory from wrapping to zero.
                        if (remaining_reg == CNT_ONE) begin
                            state_reg <= DONE;
                        end else begin
                            addr_reg <= addr_reg + ADDR_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        remaining_reg <= remaining_reg - CNT_ONE;
                        if (remaining_reg == CNT_ONE) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ucode_loader.md
UCODE_LOADER -- requirements
Module: ucode_loader

Interface
REQ-001 SHALL have parameter UCODE_DEPTH, default 64: number of uCode memory entries (power of two, 2..256).
REQ-002 SHALL have parameter INSTR_WIDTH, default 32: uCode instruction width; equals the config word width.
REQ-003 SHALL have port clk_i, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_data_i, input, INSTR_WIDTH: config stream word (header or instruction).
REQ-006 SHALL have port cfg_valid_i, input, 1: cfg_data_i valid.
REQ-007 SHALL have port cfg_ready_o, output, 1: loader accepts word; transfer = valid & ready.
REQ-008 SHALL have port seq_busy_i, input, 1: uCode sequencer is executing; new loads are blocked.
REQ-009 SHALL have port mem_we_o, output, 1: uCode memory write enable.
REQ-010 SHALL have port mem_addr_o, output, $clog2(UCODE_DEPTH): uCode memory write address.
REQ-011 SHALL have port mem_wdata_o, output, INSTR_WIDTH: uCode memory write data.
REQ-012 SHALL have port loader_busy_o, output, 1: load in progress; sequencer must not start.
REQ-013 SHALL have port done_o, output, 1: one-cycle pulse after successful load.
REQ-014 SHALL have port err_o, output, 1: one-cycle pulse when a header is rejected.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-016 Header fields SHALL be: [7:0] start address, [15:8] instruction count; bits above 15 ignored.
REQ-017 In IDLE, cfg_ready_o SHALL equal !seq_busy_i; an accepted word is a header.
REQ-018 Header with count 0 SHALL go IDLE -> DONE, no memory writes.
REQ-019 Header with start+count > UCODE_DEPTH, or start >= UCODE_DEPTH, SHALL pulse err_o next cycle and go to DRAIN with count words to discard.
REQ-020 Otherwise header SHALL load address counter = start, remaining counter = count, go to LOAD.
REQ-021 In LOAD and DRAIN, cfg_ready_o SHALL be 1 regardless of seq_busy_i.
REQ-022 Each LOAD transfer SHALL produce, registered, exactly one cycle later: mem_we_o=1, mem_addr_o=current address, mem_wdata_o=word; address increments by 1, remaining decrements by 1.
REQ-023 Without transfer, mem_we_o SHALL be 0 next cycle; valid gaps stall the load without loss.
REQ-024 Last LOAD transfer (remaining==1) SHALL go to DONE; last DRAIN transfer SHALL go to IDLE with no done_o.
REQ-025 DRAIN transfers SHALL never assert mem_we_o.
REQ-026 DONE SHALL last one cycle: done_o=1, cfg_ready_o=0, then IDLE; done_o coincides with or follows the final mem_we_o cycle, never precedes it.
REQ-027 loader_busy_o SHALL be 1 in LOAD, DRAIN, DONE and in the cycle of the final write; 0 in IDLE otherwise.
REQ-028 Address arithmetic SHALL be computed at 9 bits to avoid wrap in the range check; the address counter never wraps in LOAD.
REQ-029 Total latency header-to-done_o for count N with no gaps SHALL be N+2 cycles.

Reset
REQ-030 rst_i high at a clock edge SHALL force IDLE, counters 0, and all outputs 0 (cfg_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, loader_busy_o, done_o, err_o), including mid-LOAD; partially written memory is not reverted.
REQ-031 cfg_ready_o SHALL be 0 in the reset cycle and follow REQ-017 from the first cycle after reset.

Structure
REQ-032 Header field offsets/widths, the loader state enum and the uCode address type ($clog2(UCODE_DEPTH)) SHALL live in pkg_ucode_sequencer, sharing pkg_common constants.
REQ-033 Single flat module; no sub-modules.

Verification
REQ-034 Header start=4,count=3 then words A,B,C back-to-back -> writes (4,A),(5,B),(6,C) on consecutive cycles, done_o once, 5 cycles header-to-done.
REQ-035 Header start=62,count=3 (DEPTH 64) -> err_o one pulse, 3 words accepted, zero writes, no done_o.
REQ-036 seq_busy_i=1 in IDLE with valid header -> cfg_ready_o=0 until busy drops; then accepted; busy rising mid-LOAD does not stall.
REQ-037 Header start=0,count=0 -> done_o pulse 2 cycles after header, no mem_we_o.
REQ-038 Header start=10,count=4, random valid gaps -> writes 10..13 in order, data intact.
REQ-039 rst_i asserted after 2 of 4 words -> outputs 0 next cycle; fresh header afterward loads correctly.
